// File: rtl/eeg_sample_packer.sv
// Packs channel-ordered EEG samples into DATA_WIDTH-bit words and writes them sequentially to the dataset memory.
// Optional build macro EEG_PACKER_BYTESWAP_EN byte-swaps each sample before packing (big-endian EDF sources).
module eeg_sample_packer #(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int DATA_WIDTH    = 128,
  parameter int NUM_CHANNELS  = 64,
  parameter int DATASET_DEPTH = 1024,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  input  logic [5:0]              s_chan,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    seq_error,
  output logic [31:0]             words_written,
  output logic [31:0]             frames_written
);

  localparam int SPW    = DATA_WIDTH / SAMPLE_WIDTH;
  localparam int LANE_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(SPW - 1);
  localparam logic [5:0]            LAST_CH   = 6'(NUM_CHANNELS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATASET_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

  state_t                  r_state, w_next;
  logic [LANE_W-1:0]       r_lane;
  logic [5:0]              r_exp;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_seq_err;
  logic [31:0]             r_words, r_frames;
  logic [DATA_WIDTH-1:0]   r_word_p0;
  logic                    r_vld_p1;
  logic [ADDR_WIDTH-1:0]   r_wr_addr_p1;
  logic [DATA_WIDTH-1:0]   r_wr_data_p1;

  logic                    w_final_wr, w_accept, w_match;
  logic signed [SAMPLE_WIDTH-1:0] w_sample;
  logic [DATA_WIDTH-1:0]   w_word;

  function automatic logic signed [SAMPLE_WIDTH-1:0] f_pack(input logic [SAMPLE_WIDTH-1:0] s);
`ifdef EEG_PACKER_BYTESWAP_EN
    return {s[7:0], s[SAMPLE_WIDTH-1:8]};
`else
    return s;
`endif
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_addr_next(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? a : a + 1'b1;
  endfunction

  // A write to the last address is always the final one; capture is closed while it is on the bus.
  assign w_final_wr = r_vld_p1 && (r_wr_addr_p1 == LAST_ADDR);
  assign s_ready    = (r_state == S_CAPTURE) && !w_final_wr;
  assign w_accept   = s_valid && s_ready;
  assign w_match    = (s_chan == r_exp);
  assign w_sample   = f_pack(s_data);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (w_final_wr) w_next = S_DONE;
        else if (stop)  w_next = S_FLUSH;
      end
      S_FLUSH:   w_next = S_DONE;
      S_DONE:    if (!start) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Lane 0 starts a fresh word so unfilled upper lanes are always zero for a flush.
  always_comb begin
    w_word = (r_lane == '0) ? '0 : r_word_p0;
    w_word[SAMPLE_WIDTH*int'(r_lane) +: SAMPLE_WIDTH] = w_sample;
  end

  // p0: partial word assembly
  always_ff @(posedge clk) begin
    if (w_accept && w_match) r_word_p0 <= w_word;
  end

  // p1: memory write stage and capture control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lane       <= '0;
      r_exp        <= '0;
      r_addr       <= '0;
      r_seq_err    <= 1'b0;
      r_words      <= '0;
      r_frames     <= '0;
      r_vld_p1     <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else begin
      r_state  <= w_next;
      r_vld_p1 <= 1'b0;
      if (r_state == S_IDLE && start) begin
        r_lane    <= '0;
        r_exp     <= '0;
        r_addr    <= '0;
        r_seq_err <= 1'b0;
        r_words   <= '0;
        r_frames  <= '0;
      end else if (w_accept) begin
        if (w_match) begin
          if (s_chan == LAST_CH) begin
            r_exp    <= '0;
            r_frames <= r_frames + 32'd1;
          end else begin
            r_exp <= r_exp + 6'd1;
          end
          if (r_lane == LAST_LANE) begin
            r_lane       <= '0;
            r_vld_p1     <= 1'b1;
            r_wr_addr_p1 <= r_addr;
            r_wr_data_p1 <= w_word;
            r_addr       <= f_addr_next(r_addr);
            r_words      <= r_words + 32'd1;
          end else begin
            r_lane <= r_lane + 1'b1;
          end
        end else begin
          // Out-of-order channel: drop it and hunt for the next channel 0.
          r_seq_err <= 1'b1;
          r_exp     <= '0;
          r_lane    <= '0;
        end
      end else if (r_state == S_FLUSH && r_lane != '0) begin
        r_lane       <= '0;
        r_vld_p1     <= 1'b1;
        r_wr_addr_p1 <= r_addr;
        r_wr_data_p1 <= r_word_p0;
        r_addr       <= f_addr_next(r_addr);
        r_words      <= r_words + 32'd1;
      end
    end
  end

  assign wr_en          = r_vld_p1;
  assign wr_addr        = r_wr_addr_p1;
  assign wr_data        = r_wr_data_p1;
  assign busy           = (r_state == S_CAPTURE) || (r_state == S_FLUSH);
  assign done           = (r_state == S_DONE);
  assign seq_error      = r_seq_err;
  assign words_written  = r_words;
  assign frames_written = r_frames;

endmodule

// File: tb/tb_eeg_sample_packer.sv
// Directed bench for eeg_sample_packer: default-depth instance plus a 4-word-deep instance for the memory-full case.
module tb_eeg_sample_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, s_valid;
  logic [15:0] s_data;
  logic [5:0]  s_chan;

  logic         s_ready, wr_en, busy, done, seq_error;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic [31:0]  words_written, frames_written;

  logic         s_ready4, wr_en4, busy4, done4, seq_error4;
  logic [1:0]   wr_addr4;
  logic [127:0] wr_data4;
  logic [31:0]  words4, frames4;

  eeg_sample_packer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .seq_error(seq_error),
    .words_written(words_written), .frames_written(frames_written)
  );

  eeg_sample_packer #(.DATASET_DEPTH(4), .ADDR_WIDTH(2)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data), .s_chan(s_chan),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .busy(busy4), .done(done4), .seq_error(seq_error4),
    .words_written(words4), .frames_written(frames4)
  );

  int tests = 0;
  int fails = 0;

  logic [9:0]   log_addr[$];
  logic [127:0] log_data[$];
  logic [1:0]   log4_addr[$];
  logic [127:0] log4_data[$];

  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (wr_en4) begin
      log4_addr.push_back(wr_addr4);
      log4_data.push_back(wr_data4);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected words are written as received; the byte-swap build swaps every lane.
  function automatic logic [127:0] lanes(input logic [127:0] w);
    logic [127:0] r;
    r = w;
`ifdef EEG_PACKER_BYTESWAP_EN
    for (int k = 0; k < 8; k++) r[16*k +: 16] = {w[16*k +: 8], w[16*k+8 +: 8]};
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [5:0] c);
    s_valid = 1'b1;
    s_data  = d;
    s_chan  = c;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic restart();
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
    log4_addr.delete();
    log4_data.delete();
    start = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0; s_chan = '0;
    tick();
    tick();
    chk("rst_wr_en",   128'(wr_en), 128'd0);
    chk("rst_addr",    128'(wr_addr), 128'd0);
    chk("rst_data",    wr_data, 128'd0);
    chk("rst_busy",    128'(busy), 128'd0);
    chk("rst_done",    128'(done), 128'd0);
    chk("rst_seqerr",  128'(seq_error), 128'd0);
    chk("rst_words",   128'(words_written), 128'd0);
    chk("rst_frames",  128'(frames_written), 128'd0);
    chk("rst_ready",   128'(s_ready), 128'd0);
    chk("rst4_state",  128'({busy4, done4, seq_error4, s_ready4}), 128'd0);
    chk("rst4_cnt",    128'({words4, frames4}), 128'd0);

    // One word of eight samples, written one cycle after the last accept
    restart();
    chk("cap_busy",  128'(busy), 128'd1);
    chk("cap_ready", 128'(s_ready), 128'd1);
    for (int i = 0; i < 8; i++) send(16'(i + 1), 6'(i));
    chk("w1_en",    128'(wr_en), 128'd1);
    chk("w1_addr",  128'(wr_addr), 128'd0);
    chk("w1_data",  wr_data, lanes(128'h0008_0007_0006_0005_0004_0003_0002_0001));
    chk("w1_words", 128'(words_written), 128'd1);
    tick();
    chk("w1_en_off", 128'(wr_en), 128'd0);

    // Rest of the frame: eight words total, one frame
    for (int i = 8; i < 64; i++) send(16'(16'h0100 + i), 6'(i));
    tick();
    chk("fr_frames", 128'(frames_written), 128'd1);
    chk("fr_words",  128'(words_written), 128'd8);
    chk("fr_seqerr", 128'(seq_error), 128'd0);
    chk("fr_nwr",    128'(log_addr.size()), 128'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("fr_addr%0d", i), 128'(log_addr[i]), 128'(i));
    chk("fr_word1",  log_data[1], lanes(128'h010F_010E_010D_010C_010B_010A_0109_0108));

    // Stop with three lanes filled: zero-padded flush
    restart();
    for (int i = 0; i < 3; i++) send(16'(i + 1), 6'(i));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("fl_busy",  128'(busy), 128'd1);
    tick();
    chk("fl_en",     128'(wr_en), 128'd1);
    chk("fl_addr",   128'(wr_addr), 128'd0);
    chk("fl_data",   wr_data, lanes(128'h0000_0000_0000_0000_0000_0003_0002_0001));
    chk("fl_words",  128'(words_written), 128'd1);
    chk("fl_frames", 128'(frames_written), 128'd0);
    chk("fl_done",   128'(done), 128'd1);
    chk("fl_busy2",  128'(busy), 128'd0);

    // Stop together with the word-completing sample: flush writes nothing
    restart();
    for (int i = 0; i < 7; i++) send(16'(i + 1), 6'(i));
    s_valid = 1'b1; s_data = 16'h0008; s_chan = 6'd7; stop = 1'b1;
    tick();
    s_valid = 1'b0; stop = 1'b0;
    chk("sf_en",   128'(wr_en), 128'd1);
    chk("sf_data", wr_data, lanes(128'h0008_0007_0006_0005_0004_0003_0002_0001));
    tick();
    chk("sf_en2",   128'(wr_en), 128'd0);
    chk("sf_words", 128'(words_written), 128'd1);
    chk("sf_done",  128'(done), 128'd1);
    tick();
    chk("sf_hold",  128'(done), 128'd1);
    start = 1'b0;
    tick();
    chk("sf_idle",  128'(done), 128'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop", 128'({busy, done, wr_en}), 128'd0);

    // Out-of-order channel, resync on channel 0
    restart();
    send(16'h0011, 6'd0);
    send(16'h0012, 6'd1);
    send(16'h0015, 6'd5);
    chk("se_set", 128'(seq_error), 128'd1);
    send(16'h0013, 6'd3);
    for (int i = 0; i < 8; i++) send(16'(16'h0020 + i), 6'(i));
    chk("se_en",   128'(wr_en), 128'd1);
    chk("se_addr", 128'(wr_addr), 128'd0);
    chk("se_data", wr_data, lanes(128'h0027_0026_0025_0024_0023_0022_0021_0020));
    tick();
    chk("se_nwr",    128'(log_addr.size()), 128'd1);
    chk("se_sticky", 128'(seq_error), 128'd1);
    chk("se_words",  128'(words_written), 128'd1);

    // Memory full on the 4-deep instance
    restart();
    for (int i = 0; i < 40; i++) begin
      send(16'(i), 6'(i));
      if (i == 31) begin
        chk("mf_last_en",    128'(wr_en4), 128'd1);
        chk("mf_last_addr",  128'(wr_addr4), 128'd3);
        chk("mf_last_ready", 128'(s_ready4), 128'd0);
      end
    end
    tick();
    tick();
    chk("mf_nwr",   128'(log4_addr.size()), 128'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("mf_addr%0d", i), 128'(log4_addr[i]), 128'(i));
    chk("mf_word3", log4_data[3], lanes(128'h001F_001E_001D_001C_001B_001A_0019_0018));
    chk("mf_done",  128'(done4), 128'd1);
    chk("mf_ready", 128'(s_ready4), 128'd0);
    chk("mf_words", 128'(words4), 128'd4);
    chk("mf_big_words", 128'(words_written), 128'd5);

    // Reset mid-capture discards the partial word
    restart();
    for (int i = 0; i < 13; i++) send(16'(16'h0050 + i), 6'(i));
    start = 1'b0;
    rst = 1'b1;
    tick();
    chk("mr_wr_en", 128'(wr_en), 128'd0);
    chk("mr_data",  wr_data, 128'd0);
    chk("mr_addr",  128'(wr_addr), 128'd0);
    chk("mr_words", 128'(words_written), 128'd0);
    chk("mr_state", 128'({busy, done, s_ready}), 128'd0);
    rst = 1'b0;
    start = 1'b1;
    tick();
    send(16'h1234, 6'd0);
    for (int i = 1; i < 8; i++) send(16'(16'h0060 + i), 6'(i));
    chk("mr_en2",   128'(wr_en), 128'd1);
    chk("mr_addr2", 128'(wr_addr), 128'd0);
    chk("mr_data2", wr_data, lanes(128'h0067_0066_0065_0064_0063_0062_0061_1234));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
